// File: rtl/dmem_responder_if.sv
// Request/response channel between the core data port and dmem_responder.
// The core side drives the request and consumes the single-cycle response pulse.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a 64-bit synchronous RAM,
// with little-endian lane extraction, sign/zero extension and read-modify-write stores.
module dmem_responder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              aresetn,
  dmem_responder_if.slave   bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_D = 2'b11;

  state_t              state;
  logic                we_q;
  logic [ADDR_W+2:0]   addr_q;
  logic [63:0]         wdata_q;
  logic [1:0]          size_q;
  logic                uns_q;

  logic [5:0]          lane_shift;
  logic [63:0]         size_mask;
  logic [63:0]         merged;
  logic [63:0]         load_data;

  function automatic logic [63:0] mask_of(input logic [1:0] size);
    case (size)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  // Byte offset within the doubleword, scaled to a bit shift for lane placement.
  assign lane_shift = {addr_q[2:0], 3'b000};
  assign size_mask  = mask_of(size_q);
  assign merged     = (ram_rdata & ~(size_mask << lane_shift))
                    | ((wdata_q & size_mask) << lane_shift);
  assign load_data  = extend(ram_rdata >> lane_shift, size_q, uns_q);

  // RAM strobes come straight from state so an asynchronous reset drops them at once.
  assign bus.req_ready = (state == IDLE);
  assign ram_en        = (state == RD) || (state == WR);
  assign ram_we        = (state == WR);
  assign ram_addr      = addr_q[ADDR_W+2:3];
  assign ram_wdata     = wdata_q;

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[ADDR_W+2:0];
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            if (misaligned(bus.req_size, bus.req_addr[2:0])) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_we && bus.req_size == SIZE_D) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          if (we_q) begin
            wdata_q <= merged;
            state   <= WR;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_data;
          end
        end
        WR: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with a behavioural 4096 x 64 sync RAM.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata = '0;

  logic [63:0] mem [0:4095];
  int          wr_cnt = 0;
  int          en_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(12)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Issue one request; lat counts edges from the accept edge to the response sample.
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output int lat, output logic [63:0] rdata, output logic err);
    @(negedge clk);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat   = -1;
    rdata = '1;
    err   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.resp_valid) begin
        lat   = i;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.resp_err); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b want 0", ram_en); end
  endtask

  task automatic test_double();
    int lat; logic [63:0] rd; logic err; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 64'h40, 64'h1122334455667788, 2'b11, 1'b0, lat, rd, err);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sd_latency got %0d want 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sd_err got %b want 0", err); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL sd_rdata got %h want 0", rd); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sd_writes got %0d want 1", wr_cnt - w0); end
    checks++; if (mem[8] !== 64'h1122334455667788) begin errors++; $display("FAIL sd_mem got %h want 1122334455667788", mem[8]); end
    do_req(1'b0, 64'h40, 64'h0, 2'b11, 1'b0, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency got %0d want 3", lat); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_data got %h want 1122334455667788", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_err got %b want 0", err); end
  endtask

  task automatic test_sub_store();
    int lat; logic [63:0] rd; logic err;
    do_req(1'b1, 64'h43, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 1'b0, lat, rd, err);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency got %0d want 4", lat); end
    checks++; if (mem[8] !== 64'h11223344AB667788) begin errors++; $display("FAIL sb_mem got %h want 11223344ab667788", mem[8]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sb_err got %b want 0", err); end
    do_req(1'b1, 64'h44, 64'h0000_0000_8000_0000, 2'b10, 1'b0, lat, rd, err);
    checks++; if (mem[8] !== 64'h80000000AB667788) begin errors++; $display("FAIL sw_mem got %h want 80000000ab667788", mem[8]); end
  endtask

  task automatic test_loads();
    int lat; logic [63:0] rd; logic err;
    do_req(1'b0, 64'h43, 64'h0, 2'b00, 1'b0, lat, rd, err);
    checks++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL lb_signed got %h want ffffffffffffffab", rd); end
    do_req(1'b0, 64'h43, 64'h0, 2'b00, 1'b1, lat, rd, err);
    checks++; if (rd !== 64'h00000000000000AB) begin errors++; $display("FAIL lb_unsigned got %h want ab", rd); end
    do_req(1'b0, 64'h44, 64'h0, 2'b10, 1'b0, lat, rd, err);
    checks++; if (rd !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL lw_signed got %h want ffffffff80000000", rd); end
    do_req(1'b0, 64'h46, 64'h0, 2'b01, 1'b1, lat, rd, err);
    checks++; if (rd !== 64'h0000000000008000) begin errors++; $display("FAIL lh_unsigned got %h want 8000", rd); end
    do_req(1'b0, 64'h40, 64'h0, 2'b10, 1'b0, lat, rd, err);
    checks++; if (rd !== 64'hFFFFFFFFAB667788) begin errors++; $display("FAIL lw_low got %h want ffffffffab667788", rd); end
    do_req(1'b0, 64'hFFFF_0000_0000_8040, 64'h0, 2'b11, 1'b0, lat, rd, err);
    checks++; if (rd !== 64'h80000000AB667788) begin errors++; $display("FAIL ld_wrap got %h want 80000000ab667788", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [63:0] rd; logic err; int e0; int w0;
    e0 = en_cnt; w0 = wr_cnt;
    do_req(1'b0, 64'h41, 64'h0, 2'b01, 1'b0, lat, rd, err);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_ld_latency got %0d want 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_ld_err got %b want 1", err); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mis_ld_rdata got %h want 0", rd); end
    do_req(1'b1, 64'h42, 64'hDEADBEEF, 2'b10, 1'b0, lat, rd, err);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_st_latency got %0d want 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_st_err got %b want 1", err); end
    checks++; if (en_cnt - e0 !== 0) begin errors++; $display("FAIL mis_ram_en got %0d want 0", en_cnt - e0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mis_writes got %0d want 0", wr_cnt - w0); end
    checks++; if (mem[8] !== 64'h80000000AB667788) begin errors++; $display("FAIL mis_mem got %h want 80000000ab667788", mem[8]); end
  endtask

  task automatic test_back_to_back();
    int k_ready = -1; int k_a = -1; int k_b = -1; int n_acc = 0; logic drop = 1'b0;
    logic [63:0] a_data = '0;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_addr = 64'h40; bus.req_size = 2'b11; bus.req_unsigned = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_we = 1'b1; bus.req_addr = 64'h48; bus.req_wdata = 64'h0123456789ABCDEF;
      end
      if (drop) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (k_a < 0) begin k_a = k; a_data = bus.resp_rdata; end
        else if (k_b < 0) k_b = k;
      end
      if (bus.req_valid && bus.req_ready) begin
        n_acc++;
        if (k_ready < 0) k_ready = k;
        drop = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (k_a !== 3) begin errors++; $display("FAIL b2b_a_latency got %0d want 3", k_a); end
    checks++; if (a_data !== 64'h80000000AB667788) begin errors++; $display("FAIL b2b_a_data got %h want 80000000ab667788", a_data); end
    checks++; if (k_ready !== 4) begin errors++; $display("FAIL b2b_ready_cycle got %0d want 4", k_ready); end
    checks++; if (n_acc !== 1) begin errors++; $display("FAIL b2b_accepts got %0d want 1", n_acc); end
    checks++; if (k_b !== 6) begin errors++; $display("FAIL b2b_b_latency got %0d want 6", k_b); end
    checks++; if (mem[9] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL b2b_mem got %h want 0123456789abcdef", mem[9]); end
  endtask

  task automatic test_reset_in_write();
    int lat; logic [63:0] rd; logic err; int w0; int seen = 0;
    do_req(1'b1, 64'h50, 64'hCAFEF00D12345678, 2'b11, 1'b0, lat, rd, err);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 64'h51; bus.req_wdata = 64'h99; bus.req_size = 2'b00;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ram_we) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rw_reach_wr got %0d want 1", seen); end
    w0 = wr_cnt;
    #1 aresetn = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rw_async_we got %b want 0", ram_we); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rw_async_en got %b want 0", ram_en); end
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rw_writes got %0d want 0", wr_cnt - w0); end
    checks++; if (mem[10] !== 64'hCAFEF00D12345678) begin errors++; $display("FAIL rw_mem got %h want cafef00d12345678", mem[10]); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rw_valid got %b want 0", bus.resp_valid); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_double();
    test_sub_store();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
